// File: rtl/csa_4bit_6oper.sv
// Six-operand unsigned adder: three levels of 3:2 carry-save compressors
// feeding one ripple carry-propagate adder, with a single output register.
module csa_4bit_6oper #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   operA,
    input  logic [WIDTH-1:0]   operB,
    input  logic [WIDTH-1:0]   operC,
    input  logic [WIDTH-1:0]   operD,
    input  logic [WIDTH-1:0]   operE,
    input  logic [WIDTH-1:0]   operF,
    output logic [WIDTH+2:0]   result,
    output logic               out_valid
);

    localparam int RW = WIDTH + 3;

    logic [RW-1:0] w_a, w_b, w_c, w_d, w_e, w_f;
    logic [RW-1:0] w_s1, w_c1, w_s2, w_c2, w_s3, w_c3, w_s4, w_c4;
    logic [RW-1:0] w_sum;
    logic [RW-1:0] w_rc;

    logic [RW-1:0] r_result;
    logic          r_valid;

    assign w_a = {3'b000, operA};
    assign w_b = {3'b000, operB};
    assign w_c = {3'b000, operC};
    assign w_d = {3'b000, operD};
    assign w_e = {3'b000, operE};
    assign w_f = {3'b000, operF};

    // Each level is a row of full adders; carries move up one bit position.
    assign w_s1 = w_a ^ w_b ^ w_c;
    assign w_c1 = ((w_a & w_b) | (w_a & w_c) | (w_b & w_c)) << 1;
    assign w_s2 = w_d ^ w_e ^ w_f;
    assign w_c2 = ((w_d & w_e) | (w_d & w_f) | (w_e & w_f)) << 1;

    assign w_s3 = w_s1 ^ w_c1 ^ w_s2;
    assign w_c3 = ((w_s1 & w_c1) | (w_s1 & w_s2) | (w_c1 & w_s2)) << 1;

    assign w_s4 = w_s3 ^ w_c3 ^ w_c2;
    assign w_c4 = ((w_s3 & w_c3) | (w_s3 & w_c2) | (w_c3 & w_c2)) << 1;

    // Final ripple adder; the carry out of the top bit is always zero.
    assign w_rc[0] = 1'b0;
    for (genvar i = 0; i < RW; i++) begin : g_cpa
        assign w_sum[i] = w_s4[i] ^ w_c4[i] ^ w_rc[i];
        if (i < RW - 1) begin : g_carry
            assign w_rc[i+1] = (w_s4[i] & w_c4[i]) | (w_s4[i] & w_rc[i]) | (w_c4[i] & w_rc[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_result <= w_sum;
            end
        end
    end

    assign result    = r_result;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_csa_4bit_6oper.sv
// Randomised scoreboard bench for csa_4bit_6oper: driver pushes the expected
// {out_valid, result} for every edge, a monitor pops and compares after it.
module tb_csa_4bit_6oper;

    localparam int WIDTH = 4;
    localparam int RW    = WIDTH + 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] operA, operB, operC, operD, operE, operF;
    logic [RW-1:0]    result;
    logic             out_valid;

    logic [RW:0]      exp_q[$];
    string            name_q[$];
    int               n_checks;
    int               n_pass;
    int               model_result;

    csa_4bit_6oper #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .operA     (operA),
        .operB     (operB),
        .operC     (operC),
        .operD     (operD),
        .operE     (operE),
        .operF     (operF),
        .result    (result),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs (called just after a falling edge) and record
    // what the next rising edge must produce.
    task automatic step(input logic rst, input logic v,
                        input int a, input int b, input int c,
                        input int d, input int e, input int f,
                        input string name);
        logic exp_v;
        rst_n    = rst;
        in_valid = v;
        operA = a[WIDTH-1:0]; operB = b[WIDTH-1:0]; operC = c[WIDTH-1:0];
        operD = d[WIDTH-1:0]; operE = e[WIDTH-1:0]; operF = f[WIDTH-1:0];
        if (!rst) begin
            model_result = 0;
            exp_v = 1'b0;
        end else if (v) begin
            model_result = a + b + c + d + e + f;
            exp_v = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
        exp_q.push_back({exp_v, RW'(model_result)});
        name_q.push_back(name);
        @(negedge clk);
    endtask

    // Monitor: one expected entry per rising edge, compared 1 time unit later.
    initial begin
        logic [RW:0] exp;
        string       nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                n_checks++;
                if ({out_valid, result} === exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got valid=%0b result=%0d, expected valid=%0b result=%0d",
                             nm, out_valid, result, exp[RW], exp[RW-1:0]);
                end
            end
        end
    end

    initial begin
        int t;
        n_checks = 0;
        n_pass   = 0;
        model_result = 0;
        rst_n = 1'b0; in_valid = 1'b0;
        operA = '0; operB = '0; operC = '0; operD = '0; operE = '0; operF = '0;
        @(negedge clk);

        step(0, 1, 15, 15, 15, 15, 15, 15, "reset_0");
        step(0, 1, 15, 15, 15, 15, 15, 15, "reset_1");
        step(1, 1, 15, 15, 15, 15, 15, 15, "post_reset_max");
        step(1, 1, 0, 0, 0, 0, 0, 0, "all_zero");
        step(1, 1, 15, 15, 15, 15, 15, 15, "all_max");
        step(1, 1, 1, 2, 3, 4, 5, 6, "mixed_21");
        step(1, 1, 15, 0, 15, 0, 15, 0, "mixed_45");
        step(1, 1, 8, 8, 8, 8, 8, 8, "carry_48");
        step(1, 0, 15, 15, 15, 15, 15, 15, "hold_48");
        step(1, 0, 15, 15, 15, 15, 15, 15, "hold_48_again");

        for (int i = 0; i < 1200; i++) begin
            if (i == 600) begin
                step(0, 1, 15, 15, 15, 15, 15, 15, "rand_reset");
            end else begin
                step(1, ($urandom_range(0, 9) != 0),
                     $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                     "random");
            end
        end

        t = 0;
        while (exp_q.size() > 0 && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expected results never compared, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
